// File: rtl/psad_min_select.sv
// psad_min_select: tracks the minimum lane SAD over one block search
// (NUM_BATCHES beats of PIXELS_IN_BATCH packed SADs) at the end of the
// AD partial-SAD chain and presents the winner on a valid/ready port.
// Ports:
//   clk, rst_n (sync, active low)
//   psad_in/psad_valid/psad_last/psad_ready : beat input
//   result_valid/result_ready               : result handshake
//   best_sad/best_lane/best_batch           : winning candidate
//   frame_error : psad_last disagreed with the beat count this search
module psad_min_select #(
   parameter int PIXELS_IN_BATCH           = 16,
   parameter int INPUT_PSAD_BITS_PER_PIXEL = 11,
   parameter int NUM_BATCHES               = 4,
   parameter int LANE_W  =
      (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1,
   parameter int BATCH_W =
      (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] psad_in,
   input  logic psad_valid,
   input  logic psad_last,
   output logic psad_ready,
   output logic result_valid,
   input  logic result_ready,
   output logic [INPUT_PSAD_BITS_PER_PIXEL-1:0] best_sad,
   output logic [LANE_W-1:0] best_lane,
   output logic [BATCH_W-1:0] best_batch,
   output logic frame_error
);

   localparam int W = INPUT_PSAD_BITS_PER_PIXEL;
   localparam logic [BATCH_W-1:0] LAST_CNT =
      BATCH_W'(NUM_BATCHES - 1);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic accept;
   logic beat_final;

   logic [BATCH_W-1:0] cnt_q, cnt_d;
   logic err_q, err_d;

   logic [W-1:0]      comb_min;
   logic [LANE_W-1:0] comb_idx;

   logic [W-1:0]       lane_min_q, lane_min_d;
   logic [LANE_W-1:0]  lane_idx_q, lane_idx_d;
   logic [BATCH_W-1:0] batch_idx_q, batch_idx_d;
   logic s1_valid_q, s1_valid_d;
   logic s1_final_q, s1_final_d;
   logic s1_first_q, s1_first_d;

   logic [W-1:0]       run_min_q, run_min_d;
   logic [LANE_W-1:0]  run_lane_q, run_lane_d;
   logic [BATCH_W-1:0] run_batch_q, run_batch_d;
   // final beat has been folded into the running minimum
   logic s2_done_q, s2_done_d;

   // ---------------- FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_ACCUM;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ACCUM: if (accept && beat_final) state_d = ST_DRAIN;
         ST_DRAIN: if (s2_done_q)            state_d = ST_HOLD;
         ST_HOLD:  if (result_ready)         state_d = ST_ACCUM;
         default:                            state_d = ST_ACCUM;
      endcase
   end

   // ---------------- FSM: outputs
   always_comb begin
      psad_ready   = (state_q == ST_ACCUM);
      result_valid = (state_q == ST_HOLD);
   end

   assign accept     = psad_valid && psad_ready;
   assign beat_final = (cnt_q == LAST_CNT);

   // Lane minimum; strict compare while scanning upward keeps
   // the lowest lane on ties.
   always_comb begin
      comb_min = psad_in[W-1:0];
      comb_idx = '0;
      for (int i = 1; i < PIXELS_IN_BATCH; i++) begin
         if (psad_in[i*W +: W] < comb_min) begin
            comb_min = psad_in[i*W +: W];
            comb_idx = LANE_W'(i);
         end
      end
   end

   // ---------------- datapath next-state
   always_comb begin
      cnt_d       = cnt_q;
      err_d       = err_q;
      lane_min_d  = lane_min_q;
      lane_idx_d  = lane_idx_q;
      batch_idx_d = batch_idx_q;
      s1_valid_d  = accept;
      s1_final_d  = s1_final_q;
      s1_first_d  = s1_first_q;
      run_min_d   = run_min_q;
      run_lane_d  = run_lane_q;
      run_batch_d = run_batch_q;
      s2_done_d   = s1_valid_q && s1_final_q;

      if (accept) begin
         cnt_d       = beat_final ? '0 : cnt_q + 1'b1;
         lane_min_d  = comb_min;
         lane_idx_d  = comb_idx;
         batch_idx_d = cnt_q;
         s1_final_d  = beat_final;
         s1_first_d  = (cnt_q == '0);
         // first beat of a search drops the previous error
         err_d = ((cnt_q == '0) ? 1'b0 : err_q)
               | (psad_last != beat_final);
      end

      // strict compare: ties keep the earlier batch
      if (s1_valid_q &&
          (s1_first_q || (lane_min_q < run_min_q))) begin
         run_min_d   = lane_min_q;
         run_lane_d  = lane_idx_q;
         run_batch_d = batch_idx_q;
      end
   end

   // ---------------- datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         err_q       <= 1'b0;
         lane_min_q  <= '0;
         lane_idx_q  <= '0;
         batch_idx_q <= '0;
         s1_valid_q  <= 1'b0;
         s1_final_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         run_min_q   <= '0;
         run_lane_q  <= '0;
         run_batch_q <= '0;
         s2_done_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         lane_min_q  <= lane_min_d;
         lane_idx_q  <= lane_idx_d;
         batch_idx_q <= batch_idx_d;
         s1_valid_q  <= s1_valid_d;
         s1_final_q  <= s1_final_d;
         s1_first_q  <= s1_first_d;
         run_min_q   <= run_min_d;
         run_lane_q  <= run_lane_d;
         run_batch_q <= run_batch_d;
         s2_done_q   <= s2_done_d;
      end
   end

   assign best_sad    = run_min_q;
   assign best_lane   = run_lane_q;
   assign best_batch  = run_batch_q;
   assign frame_error = err_q;

endmodule

// File: tb/tb_psad_min_select.sv
// tb_psad_min_select: directed and randomized checks of psad_min_select
// against a flat whole-search minimum scan.
module tb_psad_min_select;

   localparam int P  = 16;
   localparam int W  = 11;
   localparam int NB = 4;
   localparam int LW = 4;
   localparam int BW = 2;
   localparam int RW = W + LW + BW + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [W*P-1:0] psad_in;
   logic psad_valid, psad_last, psad_ready;
   logic result_valid, result_ready;
   logic [W-1:0]  best_sad;
   logic [LW-1:0] best_lane;
   logic [BW-1:0] best_batch;
   logic frame_error;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] sads [NB][P];
   bit lasts [NB];
   bit run_to;

   psad_min_select #(
      .PIXELS_IN_BATCH(P),
      .INPUT_PSAD_BITS_PER_PIXEL(W),
      .NUM_BATCHES(NB)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .psad_in(psad_in),
      .psad_valid(psad_valid),
      .psad_last(psad_last),
      .psad_ready(psad_ready),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .best_sad(best_sad),
      .best_lane(best_lane),
      .best_batch(best_batch),
      .frame_error(frame_error)
   );

   wire [RW-1:0] res = {best_sad, best_lane, best_batch, frame_error};

   function automatic logic [W*P-1:0] pack(input int b);
      logic [W*P-1:0] v;
      for (int l = 0; l < P; l++) v[l*W +: W] = sads[b][l];
      return v;
   endfunction

   task automatic fill(input logic [W-1:0] base);
      for (int b = 0; b < NB; b++) begin
         lasts[b] = (b == NB - 1);
         for (int l = 0; l < P; l++) sads[b][l] = base;
      end
   endtask

   // Whole-search reference: scan every candidate in arrival order,
   // replace only on strictly smaller.
   task automatic model(output logic [RW-1:0] e);
      logic [W-1:0] s;
      int ln, bt;
      bit fe;
      s = sads[0][0]; ln = 0; bt = 0; fe = 0;
      for (int b = 0; b < NB; b++)
         for (int l = 0; l < P; l++)
            if (sads[b][l] < s) begin
               s = sads[b][l]; ln = l; bt = b;
            end
      for (int b = 0; b < NB; b++)
         if (lasts[b] != (b == NB - 1)) fe = 1;
      e = {s, LW'(ln), BW'(bt), fe};
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send_beat(input int b);
      int n;
      n = 0;
      psad_in    = pack(b);
      psad_last  = lasts[b];
      psad_valid = 1'b1;
      while (!psad_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) run_to = 1;
      @(negedge clk);
   endtask

   task automatic run_beats(input int from, input int to_b);
      for (int b = from; b <= to_b; b++) send_beat(b);
      psad_valid = 1'b0;
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!result_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      psad_valid = 1'b0;
      psad_last = 1'b0;
      psad_in = '0;
      result_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({res, result_valid} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got res=%h rv=%b want 0",
                  res, result_valid);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (psad_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", psad_ready);
      end
   endtask

   task automatic test_basic;
      int cyc;
      logic [RW-1:0] exp_r;
      fill(100);
      sads[2][5] = 7;
      exp_r = {11'd7, 4'd5, 2'd2, 1'b0};
      run_to = 0;
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (run_to || cyc != 2) begin
         errors++;
         $display("FAIL basic_latency: got %0d (to=%0b) want 2",
                  cyc, run_to);
      end
      checks++;
      if (res !== exp_r) begin
         errors++;
         $display("FAIL basic_result: got %h want %h", res, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_ties;
      int cyc;
      logic [RW-1:0] exp_r;
      fill(50);
      sads[0][9] = 20;
      sads[1][3] = 20;
      sads[1][2] = 20;
      exp_r = {11'd20, 4'd9, 2'd0, 1'b0};
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (res !== exp_r || cyc != 2) begin
         errors++;
         $display("FAIL tie_batch: got %h lat %0d want %h lat 2",
                  res, cyc, exp_r);
      end
      @(negedge clk);
      fill(50);
      sads[1][2] = 20;
      sads[1][3] = 20;
      exp_r = {11'd20, 4'd2, 2'd1, 1'b0};
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (res !== exp_r || cyc != 2) begin
         errors++;
         $display("FAIL tie_lane: got %h lat %0d want %h lat 2",
                  res, cyc, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int cyc;
      logic [RW-1:0] exp1, exp2;
      fill(60);
      sads[3][0] = 10;
      exp1 = {11'd10, 4'd0, 2'd3, 1'b0};
      result_ready = 1'b0;
      run_beats(0, NB - 1);
      fill(60);
      sads[0][4] = 1;
      exp2 = {11'd1, 4'd4, 2'd0, 1'b0};
      psad_in    = pack(0);
      psad_last  = lasts[0];
      psad_valid = 1'b1;
      wait_result(cyc);
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL bp_latency: got %0d want 2", cyc);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (result_valid !== 1'b1 || psad_ready !== 1'b0 ||
             res !== exp1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: rv=%b rdy=%b res=%h want 1 0 %h",
                     i, result_valid, psad_ready, res, exp1);
         end
         @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (psad_ready !== 1'b1 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: rdy=%b rv=%b want 1 0",
                  psad_ready, result_valid);
      end
      @(negedge clk);
      run_to = 0;
      run_beats(1, NB - 1);
      wait_result(cyc);
      checks++;
      if (run_to || cyc != 2 || res !== exp2) begin
         errors++;
         $display("FAIL bp_held_beat: got %h lat %0d want %h lat 2",
                  res, cyc, exp2);
      end
      @(negedge clk);
   endtask

   task automatic test_frame_error;
      int cyc;
      logic [RW-1:0] exp_r;
      fill(80);
      sads[1][7] = 3;
      lasts[1] = 1'b1;
      exp_r = {11'd3, 4'd7, 2'd1, 1'b1};
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (res !== exp_r || cyc != 2) begin
         errors++;
         $display("FAIL frame_err: got %h lat %0d want %h lat 2",
                  res, cyc, exp_r);
      end
      @(negedge clk);
      fill(80);
      sads[2][1] = 5;
      exp_r = {11'd5, 4'd1, 2'd2, 1'b0};
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (res !== exp_r || cyc != 2) begin
         errors++;
         $display("FAIL frame_clean: got %h lat %0d want %h lat 2",
                  res, cyc, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int cyc;
      int seen;
      logic [RW-1:0] exp_r;
      fill(90);
      sads[1][3] = 4;
      run_beats(0, 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({res, result_valid} !== '0 || psad_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_state: res=%h rv=%b rdy=%b",
                  res, result_valid, psad_ready);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (result_valid) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midreset_noresult: got %0d valid cycles want 0",
                  seen);
      end
      fill(11'h7ff);
      exp_r = {11'd2047, 4'd0, 2'd0, 1'b0};
      run_to = 0;
      run_beats(0, NB - 1);
      wait_result(cyc);
      checks++;
      if (run_to || res !== exp_r || cyc != 2) begin
         errors++;
         $display("FAIL midreset_fresh: got %h lat %0d want %h lat 2",
                  res, cyc, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [W*P-1:0] bus [2*NB];
      bit lst [2*NB];
      logic [RW-1:0] expv [2];
      logic [RW-1:0] got [2];
      int k, stalls, nres, cyc;
      for (int s = 0; s < 2; s++) begin
         fill(0);
         for (int b = 0; b < NB; b++)
            for (int l = 0; l < P; l++)
               sads[b][l] = W'($urandom_range(0, 2047));
         model(expv[s]);
         for (int b = 0; b < NB; b++) begin
            bus[s*NB + b] = pack(b);
            lst[s*NB + b] = lasts[b];
         end
      end
      got[0] = '0;
      got[1] = '0;
      k = 0; stalls = 0; nres = 0; cyc = 0;
      while ((k < 2*NB || nres < 2) && cyc < 60) begin
         if (k < 2*NB) begin
            psad_in    = bus[k];
            psad_last  = lst[k];
            psad_valid = 1'b1;
         end else begin
            psad_valid = 1'b0;
         end
         if (result_valid && nres < 2) begin
            got[nres] = res;
            nres++;
         end
         if (k == NB && !psad_ready) stalls++;
         if (psad_valid && psad_ready) k++;
         @(negedge clk);
         cyc++;
      end
      psad_valid = 1'b0;
      checks++;
      if (stalls != 3 || nres != 2) begin
         errors++;
         $display("FAIL b2b_stalls: got %0d stalls %0d results want 3 2",
                  stalls, nres);
      end
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (got[s] !== expv[s]) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got %h want %h",
                     s, got[s], expv[s]);
         end
      end
   endtask

   task automatic test_random;
      int cyc;
      int hold;
      logic [RW-1:0] exp_r;
      for (int t = 0; t < 12; t++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 0) ? 15 : 2047;
         for (int b = 0; b < NB; b++) begin
            lasts[b] = (b == NB - 1) ^ ($urandom_range(0, 9) == 0);
            for (int l = 0; l < P; l++)
               sads[b][l] = W'($urandom_range(0, hi));
         end
         model(exp_r);
         hold = $urandom_range(0, 3);
         result_ready = (hold == 0);
         run_to = 0;
         run_beats(0, NB - 1);
         wait_result(cyc);
         checks++;
         if (run_to || cyc != 2 || res !== exp_r) begin
            errors++;
            $display("FAIL rand[%0d]: got %h lat %0d want %h lat 2",
                     t, res, cyc, exp_r);
         end
         if (hold != 0) begin
            repeat (hold) @(negedge clk);
            checks++;
            if (result_valid !== 1'b1 || res !== exp_r) begin
               errors++;
               $display("FAIL rand_stall[%0d]: rv=%b got %h want %h",
                        t, result_valid, res, exp_r);
            end
            result_ready = 1'b1;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_ties();
      test_backpressure();
      test_frame_error();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/psad_min_select.md
Name: psad_min_select

Overview:
- Reader end of the AD partial-SAD chain: consumes the final packed psad bus leaving the last AD cell of the array, one batch of PIXELS_IN_BATCH candidate SADs per beat.
- Tracks the minimum SAD over NUM_BATCHES beats, which form one block search.
- Presents the winning candidate (batch, lane) and its SAD on a valid/ready result port.
- Sits between the AD array output and the motion-vector writer.

Parameters:
PIXELS_IN_BATCH, 16, SAD lanes per beat; same packing as the AD array.
INPUT_PSAD_BITS_PER_PIXEL, 11, width of each lane's SAD.
NUM_BATCHES, 4, beats per block search; must be >= 1.
LANE_W, $clog2(PIXELS_IN_BATCH) (min 1), derived lane index width.
BATCH_W, $clog2(NUM_BATCHES) (min 1), derived batch index width.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  synchronous active-low reset.
psad_in  input  INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH  packed SADs; lane i at bits [(i+1)*W-1:i*W].
psad_valid  input  1  psad_in holds a beat.
psad_last  input  1  producer marks final beat of the search.
psad_ready  output  1  block accepts a beat this cycle.
result_valid  output  1  result fields valid.
result_ready  input  1  downstream accepts result.
best_sad  output  INPUT_PSAD_BITS_PER_PIXEL  minimum SAD of the search.
best_lane  output  LANE_W  lane of the minimum.
best_batch  output  BATCH_W  beat index (0-based) of the minimum.
frame_error  output  1  psad_last disagreed with the beat count during this search.

Behaviour:
- Beat accepted when psad_valid && psad_ready. psad_in / psad_last are sampled only on acceptance.
- Stage 1, registered: combinational min over lanes. Ties go to the lowest lane. Registers lane_min, lane_idx, batch_idx, s1_valid, s1_final.
- Stage 2, registered: on s1_valid, running minimum update.
  - On the first beat of a search, unconditionally load lane_min.
  - Otherwise replace only if lane_min < running_min (strict). Ties keep the earlier batch.
- Beat counter 0..NUM_BATCHES-1, increments per accepted beat. The beat with counter == NUM_BATCHES-1 is final; the counter then returns to 0.
- Framing is count-governed. psad_last==1 on a non-final beat, or psad_last==0 on the final beat, sets a sticky error. The search still closes at the count. The error is cleared when the next search starts.
- FSM:
  - ACCUM: psad_ready=1. Accepting the final beat -> DRAIN.
  - DRAIN: psad_ready=0. Waits for the final beat to leave stage 2 (2 cycles after acceptance) -> HOLD.
  - HOLD: result_valid=1. result_ready -> ACCUM; counter and running minimum are re-armed.
- Latency: result_valid rises exactly 2 cycles after the final beat is accepted, when result_ready is not stalling earlier output.
- Result fields and frame_error stay stable while result_valid && !result_ready.
- No beat is accepted in DRAIN or HOLD. psad_valid held by the producer is not lost: it is accepted on the first ACCUM cycle.
- HOLD exit on the same cycle as a new psad_valid: that beat is not accepted until the next cycle (psad_ready is registered from state).
- Arithmetic is compare-only; widths equal INPUT_PSAD_BITS_PER_PIXEL, with no extension or saturation.
- Max SAD (all ones) is a legal value and can win.
- NUM_BATCHES==1: every accepted beat is final.
- Reset (rst_n==0 on a rising edge, any state):
  - state=ACCUM, counter=0, s1_valid=0.
  - best_sad=0, best_lane=0, best_batch=0, frame_error=0, result_valid=0.
  - psad_ready=1 from the first cycle after reset is released.
  - A partial search is discarded; no result is emitted for it.

Test Plan:
- Defaults, 4 beats with lane SADs all 100 except beat 2 lane 5 = 7, psad_last on beat 3, result_ready=1 -> result_valid 2 cycles after beat 3 accepted: best_sad=7, best_batch=2, best_lane=5, frame_error=0.
- Tie handling: beat 0 lane 9 = 20, beat 1 lane 3 = 20, beat 1 lane 2 = 20, all other lanes 50 -> best_batch=0, best_lane=9. Second case: single beat holding lanes 2 and 3 = 20 -> best_lane=2.
- Backpressure: result_ready=0 for 5 cycles after result_valid -> psad_ready=0, outputs stable throughout; result_ready=1 -> ACCUM next cycle; a producer beat held valid is accepted as batch 0 of the next search.
- Framing error: psad_last asserted on beat 1 of 4 -> search still closes after beat 3, frame_error=1 with the result. The next clean search reports frame_error=0.
- Reset mid-search: rst_n=0 for 1 cycle after beat 2 -> no result_valid. Next 4 beats form a fresh search with batch indices 0..3; a min of 2047 (all-ones) on every lane gives best_sad=2047, best_batch=0, best_lane=0.
- Back-to-back searches with result_ready tied 1 and psad_valid continuous -> exactly 2 stall cycles (DRAIN) plus 1 (HOLD) between searches, and both results are correct.
